// File: rtl/fb_pkg.sv
// Frame-buffer geometry and writer state encoding, shared by the VGA driver
// and the rectangle fill writer.
package fb_pkg;

   localparam int H_RES   = 160;
   localparam int V_RES   = 120;
   localparam int ADDR_W  = 15;
   localparam int COLOR_W = 24;
   localparam int COORD_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLIP = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } fb_state_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle against the frame: exclusive end
// coordinates, empty flag and clipped flag.
module rect_clip #(
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   output logic [COORD_W-1:0] x_end,
   output logic [COORD_W-1:0] y_end,
   output logic               empty,
   output logic               clipped
);

   localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
   localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

   logic [COORD_W:0] x_sum;
   logic [COORD_W:0] y_sum;
   logic             off_screen;

   // Sums carry one extra bit so x+w never wraps back on-screen.
   always_comb begin
      x_sum      = {1'b0, x} + {1'b0, w};
      y_sum      = {1'b0, y} + {1'b0, h};
      off_screen = ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);
      x_end      = (x_sum > H_LIM) ? H_LIM[COORD_W-1:0] : x_sum[COORD_W-1:0];
      y_end      = (y_sum > V_LIM) ? V_LIM[COORD_W-1:0] : y_sum[COORD_W-1:0];
      empty      = (w == '0) || (h == '0) || off_screen;
      clipped    = off_screen || (x_sum > H_LIM) || (y_sum > V_LIM);
   end

endmodule

// File: rtl/rect_fill_writer.sv
// Rectangle fill writer: clips each command to the frame and streams one
// pixel write per cycle into the back buffer, pulsing frame_done at frame end.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// CLIP  | one cycle: clip latched command, set up row_base/col/row
// FILL  | one pixel write per accepted cycle, raster order
// DONE  | frame_done pulse, clear clipped
module rect_fill_writer
   import fb_pkg::*;
#(
   parameter int H_RES   = fb_pkg::H_RES,
   parameter int V_RES   = fb_pkg::V_RES,
   parameter int ADDR_W  = fb_pkg::ADDR_W,
   parameter int COLOR_W = fb_pkg::COLOR_W,
   parameter int COORD_W = fb_pkg::COORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_x,
   input  logic [COORD_W-1:0] cmd_y,
   input  logic [COORD_W-1:0] cmd_w,
   input  logic [COORD_W-1:0] cmd_h,
   input  logic [COLOR_W-1:0] cmd_color,
   input  logic               cmd_last,
   output logic               wr_en,
   input  logic               wr_ready,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COLOR_W-1:0] wr_data,
   output logic               frame_done,
   output logic               busy,
   output logic               clipped
);

   if (H_RES * V_RES > (1 << ADDR_W)) begin : g_addr_check
      $error("rect_fill_writer: H_RES*V_RES does not fit in ADDR_W");
   end

   localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

   fb_state_t state, state_nxt;

   logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
   logic [COLOR_W-1:0] color_q;
   logic               last_q;
   logic               clipped_q;
   logic [COORD_W-1:0] col, row;
   logic [ADDR_W-1:0]  row_base;

   logic [COORD_W-1:0] x_end_c, y_end_c;
   logic               empty_c, clip_c;
   logic               last_col, last_row;

   rect_clip #(
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .COORD_W (COORD_W)
   ) u_clip (
      .x       (x_q),
      .y       (y_q),
      .w       (w_q),
      .h       (h_q),
      .x_end   (x_end_c),
      .y_end   (y_end_c),
      .empty   (empty_c),
      .clipped (clip_c)
   );

   assign last_col = (col == x_end_c - COORD_W'(1));
   assign last_row = (row == y_end_c - COORD_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         w_q       <= '0;
         h_q       <= '0;
         color_q   <= '0;
         last_q    <= 1'b0;
         clipped_q <= 1'b0;
         col       <= '0;
         row       <= '0;
         row_base  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (cmd_valid) begin
               x_q     <= cmd_x;
               y_q     <= cmd_y;
               w_q     <= cmd_w;
               h_q     <= cmd_h;
               color_q <= cmd_color;
               last_q  <= cmd_last;
            end
            CLIP: begin
               col      <= x_q;
               row      <= y_q;
               // The only multiply; FILL steps row_base by H_RES instead.
               row_base <= ADDR_W'(y_q) * H_RES_A;
               if (clip_c) clipped_q <= 1'b1;
            end
            FILL: if (wr_ready) begin
               if (last_col) begin
                  col      <= x_q;
                  row      <= row + COORD_W'(1);
                  row_base <= row_base + H_RES_A;
               end else begin
                  col <= col + COORD_W'(1);
               end
            end
            DONE: clipped_q <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      cmd_ready  = 1'b0;
      busy       = 1'b1;
      wr_en      = 1'b0;
      frame_done = 1'b0;
      wr_addr    = row_base + ADDR_W'(col);
      wr_data    = color_q;
      clipped    = clipped_q;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) state_nxt = CLIP;
         end
         CLIP: begin
            if (empty_c) state_nxt = last_q ? DONE : IDLE;
            else         state_nxt = FILL;
         end
         FILL: begin
            wr_en = 1'b1;
            if (wr_ready && last_col && last_row) state_nxt = last_q ? DONE : IDLE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
